// File: rtl/ternary_bin2trit_converter_pkg.sv
// Shared types for the binary-to-balanced-ternary converter: trit encoding,
// converter FSM states and a range helper.
package ternary_bin2trit_converter_pkg;

  typedef enum logic [1:0] {
    T_ZERO    = 2'b00,
    T_POS_ONE = 2'b01,
    T_NEG_ONE = 2'b10,
    T_INVALID = 2'b11
  } trit_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } conv_state_e;

  // Largest magnitude representable in `width` balanced trits: (3^width-1)/2.
  function automatic int unsigned t_max_magnitude(input int unsigned width);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < width; i++) p = p * 3;
    return (p - 1) / 2;
  endfunction

endpackage

// File: rtl/ternary_bin2trit_converter_div3.sv
// One balanced-ternary digit extraction step: splits acc into digit + 3*quotient
// with digit in {-1,0,+1}.
module ternary_div3_step
  import ternary_bin2trit_converter_pkg::*;
#(
  parameter int BIN_W = 16
) (
  input  logic signed [BIN_W:0] acc_i,
  output trit_t                 digit_o,
  output logic signed [BIN_W:0] quotient_o
);

  localparam int AW = BIN_W + 2;
  localparam logic signed [AW-1:0] ONE   = AW'(1);
  localparam logic signed [AW-1:0] TWO   = AW'(2);
  localparam logic signed [AW-1:0] THREE = AW'(3);

  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] rem;
  logic signed [AW-1:0] adj;
  logic signed [AW-1:0] quo;

  always_comb begin
    ext = {acc_i[BIN_W], acc_i};
    // Truncating % follows the dividend's sign; fold into a floor modulus.
    rem = ext % THREE;
    if (rem[AW-1]) rem = rem + THREE;
    digit_o = T_ZERO;
    adj     = ext;
    if (rem == ONE) begin
      digit_o = T_POS_ONE;
      adj     = ext - ONE;
    end else if (rem == TWO) begin
      digit_o = T_NEG_ONE;
      adj     = ext + ONE;
    end
    quo        = adj / THREE;
    quotient_o = quo[BIN_W:0];
  end

endmodule

// File: rtl/ternary_bin2trit_converter.sv
// Sequential signed-binary to balanced-ternary converter, one trit per cycle,
// LST first, with valid/ready on both sides and overflow/zero/neg flags.
module ternary_bin2trit_converter
  import ternary_bin2trit_converter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BIN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [BIN_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output trit_t [WIDTH-1:0]       out_trits,
  output logic                    out_overflow,
  output logic                    out_zero,
  output logic                    out_neg
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  conv_state_e           state_q;
  logic signed [BIN_W:0] acc_q;
  logic [CNT_W-1:0]      cnt_q;
  trit_t [WIDTH-1:0]     trits_q;
  trit_t [WIDTH-1:0]     trits_d;
  logic                  valid_q;
  logic                  ovf_q;
  logic                  zero_q;
  logic                  zero_d;
  logic                  neg_q;

  trit_t                 digit;
  logic signed [BIN_W:0] quo;
  logic                  load;

  ternary_div3_step #(
    .BIN_W(BIN_W)
  ) u_step (
    .acc_i     (acc_q),
    .digit_o   (digit),
    .quotient_o(quo)
  );

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign load     = in_valid && in_ready;

  always_comb begin
    trits_d = trits_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cnt_q == CNT_W'(i)) trits_d[i] = digit;
    end
    zero_d = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (trits_d[i] != T_ZERO) zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) trits_q[i] <= T_ZERO;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
    end else if (load) begin
      // Covers both the IDLE accept and the back-to-back accept in DONE.
      state_q <= CONV;
      acc_q   <= {in_data[BIN_W-1], in_data};
      neg_q   <= in_data[BIN_W-1];
      cnt_q   <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) trits_q[i] <= T_ZERO;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        CONV: begin
          acc_q   <= quo;
          trits_q <= trits_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            ovf_q   <= (quo != '0);
            zero_q  <= zero_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid    = valid_q;
  assign out_trits    = trits_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;
  assign out_neg      = neg_q;

endmodule
